// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, control encodings, control struct and decode function
package riscv_pkg;
   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_IMM    = 7'd19;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_JAL    = 7'd111;
   localparam logic [6:0] OP_JALR   = 7'd103;

   typedef enum logic [2:0] {
      IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100, IMM_NONE = 3'b111
   } imm_src_e;

   typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;

   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FUNCT = 2'b10, ALU_PASSB = 2'b11} alu_op_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        alu_src;
      logic        a_src_pc;
      logic        branch;
      logic        jump;
      logic        jump_reg;
      result_src_e result_src;
      imm_src_e    imm_src;
      alu_op_e     alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RES_ALU, IMM_NONE, ALU_ADD};

   // Opcode match implies instr[1:0]==11 since every listed opcode ends in 11
   function automatic ctrl_t decode(input logic [31:0] instr, output logic illegal);
      ctrl_t c;
      logic [2:0] f3;
      f3 = instr[14:12];
      c = CTRL_NONE;
      illegal = 1'b0;
      case (instr[6:0])
         OP_R:      begin c.reg_write = 1'b1; c.alu_op = ALU_FUNCT; end
         OP_LOAD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_I; c.result_src = RES_MEM; end
         OP_IMM:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_I; c.alu_op = ALU_FUNCT; end
         OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_S; end
         OP_BRANCH: begin c.branch = 1'b1; c.imm_src = IMM_B; c.alu_op = ALU_BR; illegal = f3[2:1] == 2'b01; end
         OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_U; c.alu_op = ALU_PASSB; end
         OP_AUIPC:  begin c.reg_write = 1'b1; c.a_src_pc = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_U; end
         OP_JAL:    begin c.reg_write = 1'b1; c.jump = 1'b1; c.imm_src = IMM_J; c.result_src = RES_PC4; end
         OP_JALR:   begin
            c.reg_write = 1'b1; c.jump = 1'b1; c.jump_reg = 1'b1; c.alu_src = 1'b1;
            c.imm_src = IMM_I; c.result_src = RES_PC4; illegal = f3 != 3'b000;
         end
         default:   illegal = 1'b1;
      endcase
      return illegal ? CTRL_NONE : c;
   endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO holding instruction word and PC
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign rdata = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: queued RV32I decode with registered valid/ready output and illegal counter
module decode_stage import riscv_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [PC_W-1:0]  out_pc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             ALUSrc,
   output logic             ASrcPC,
   output logic             Branch,
   output logic             Jump,
   output logic             JumpReg,
   output logic [1:0]       ResultSrc,
   output logic [2:0]       ImmSrc,
   output logic [1:0]       ALUOp,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             push, pop, full, empty, ill_d, ill_q;
   logic [CW-1:0]    count;
   logic [31+PC_W:0] head;
   ctrl_t            ctrl_d, ctrl_q;

   // A same-cycle pop deliberately does not open a slot for fetch
   assign in_ready = !rst && count != CW'(DEPTH);
   assign push     = in_valid && in_ready && !flush;
   assign pop      = !empty && (!out_valid || out_ready) && !flush;

   instr_fifo #(.DEPTH(DEPTH), .W(32 + PC_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({in_instr, in_pc}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb ctrl_d = decode(head[PC_W +: 32], ill_d);

   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         ctrl_q    <= CTRL_NONE;
         ill_q     <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (pop) begin
         out_valid            <= 1'b1;
         ctrl_q               <= ctrl_d;
         ill_q                <= ill_d;
         {out_instr, out_pc}  <= head;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end

   // Handshakes in a flush cycle are discarded, so they are not counted
   always_ff @(posedge clk)
      if (rst) illegal_cnt <= '0;
      else if (!flush && out_valid && out_ready && ill_q && illegal_cnt != '1)
         illegal_cnt <= illegal_cnt + CNT_W'(1);

   assign RegWrite  = ctrl_q.reg_write;
   assign MemWrite  = ctrl_q.mem_write;
   assign ALUSrc    = ctrl_q.alu_src;
   assign ASrcPC    = ctrl_q.a_src_pc;
   assign Branch    = ctrl_q.branch;
   assign Jump      = ctrl_q.jump;
   assign JumpReg   = ctrl_q.jump_reg;
   assign ResultSrc = ctrl_q.result_src;
   assign ImmSrc    = ctrl_q.imm_src;
   assign ALUOp     = ctrl_q.alu_op;
   assign illegal   = ill_q;

   assert property (@(posedge clk) disable iff (rst) full |-> !push);
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage with hand-computed control words
module tb_decode_stage;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = 2;
   localparam logic [14:0] C_NONE  = 15'b0000000_00_111_00_0;
   localparam logic [14:0] C_ILL   = 15'b0000000_00_111_00_1;
   localparam logic [14:0] C_ADDI  = 15'b1010000_00_000_10_0;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]      in_instr, out_instr;
   logic [PC_W-1:0]  in_pc, out_pc;
   logic             RegWrite, MemWrite, ALUSrc, ASrcPC, Branch, Jump, JumpReg, illegal;
   logic [1:0]       ResultSrc, ALUOp;
   logic [2:0]       ImmSrc;
   logic [CNT_W-1:0] illegal_cnt;
   logic [14:0]      ctrl_obs;

   always #5 clk = ~clk;

   decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ASrcPC(ASrcPC),
      .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   assign ctrl_obs = {RegWrite, MemWrite, ALUSrc, ASrcPC, Branch, Jump, JumpReg, ResultSrc, ImmSrc, ALUOp, illegal};

   logic [31:0] sw_instr [13] = '{
      32'h00500093, 32'h0000A103, 32'h0020A223, 32'h00208463, 32'h123451B7, 32'h00001217, 32'h010000EF,
      32'h00008067, 32'h002082B3, 32'hFFFFFFFF, 32'h00009067, 32'h0020A463, 32'h00500090};
   logic [14:0] sw_ctrl [13] = '{
      15'b1010000_00_000_10_0, 15'b1010000_01_000_00_0, 15'b0110000_00_001_00_0, 15'b0000100_00_010_01_0,
      15'b1010000_00_011_11_0, 15'b1011000_00_011_00_0, 15'b1000010_10_100_00_0, 15'b1010011_10_000_00_0,
      15'b1000000_00_111_10_0, C_ILL, C_ILL, C_ILL, C_ILL};

   int n_tests = 0, n_fail = 0, exp_cnt = 0;
   logic [31:0]     q_instr [$];
   logic [PC_W-1:0] q_pc    [$];
   logic [14:0]     q_ctrl  [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] ins, input logic [PC_W-1:0] pc, input logic [14:0] c);
      q_instr.push_back(ins);
      q_pc.push_back(pc);
      q_ctrl.push_back(c);
   endtask

   // Called on a negedge; returns on the negedge after the word was accepted
   task automatic push_word(input logic [31:0] ins, input logic [PC_W-1:0] pc);
      bit ok;
      int n = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      do begin
         ok = in_ready;
         @(negedge clk);
         n++;
      end while (!ok && n < 50);
      if (!ok) check("push timeout", 0, 1);
   endtask

   task automatic drain(input int n, input string tag, input bit b2b);
      int got = 0, cyc = 0, first = 0, last = 0;
      while (got < n && cyc < 200) begin
         if (out_valid && out_ready) begin
            if (q_ctrl.size() == 0) begin
               check({tag, " extra"}, 1, 0);
               break;
            end
            check({tag, " cnt"}, illegal_cnt, exp_cnt);
            check({tag, " ctrl"}, ctrl_obs, q_ctrl[0]);
            check({tag, " instr"}, out_instr, q_instr[0]);
            check({tag, " pc"}, out_pc, q_pc[0]);
            if (q_ctrl[0][0] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            void'(q_ctrl.pop_front());
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
            if (got == 0) first = cyc;
            last = cyc;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, " count"}, got, n);
      if (b2b) check({tag, " back-to-back"}, last - first, n - 1);
   endtask

   initial begin
      int seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst ctrl", ctrl_obs, C_NONE);
      check("rst cnt", illegal_cnt, 0);
      check("rst out_pc", out_pc, 0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready after rst", in_ready, 1);

      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h10;
      @(negedge clk);
      in_valid = 1'b0;
      check("lat c+1 valid", out_valid, 0);
      @(negedge clk);
      check("lat c+2 valid", out_valid, 1);
      check("single ctrl", ctrl_obs, C_ADDI);
      check("single pc", out_pc, 32'h10);
      check("single instr", out_instr, 32'h00500093);
      out_ready = 1'b1;
      @(negedge clk);
      check("single consumed", out_valid, 0);

      fork
         begin
            for (int i = 0; i < 13; i++) begin
               expect_word(sw_instr[i], 32'h1000 + 4 * i, sw_ctrl[i]);
               push_word(sw_instr[i], 32'h1000 + 4 * i);
            end
            in_valid = 1'b0;
         end
         drain(13, "sweep", 1'b1);
      join
      check("sweep cnt saturated", illegal_cnt, 3);

      out_ready = 1'b0;
      push_word(32'h00500093, 32'h40);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst out_valid", out_valid, 0);
      check("midrst cnt", illegal_cnt, 0);
      check("midrst ctrl", ctrl_obs, C_NONE);
      check("midrst out_pc", out_pc, 0);
      rst = 1'b0;
      exp_cnt = 0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         expect_word(32'h00000093 | (i << 20), 32'h100 + 4 * i, C_ADDI);
         push_word(32'h00000093 | (i << 20), 32'h100 + 4 * i);
      end
      check("bp ready with 3 queued", in_ready, 1);
      expect_word(32'h00400093, 32'h110, C_ADDI);
      push_word(32'h00400093, 32'h110);
      in_instr = 32'h00A00093; in_pc = 32'h1FC;
      check("bp full", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp stall ready", in_ready, 0);
         check("bp stall valid", out_valid, 1);
         check("bp stall pc", out_pc, 32'h100);
         check("bp stall instr", out_instr, 32'h00000093);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(5, "bp drain", 1'b1);
      check("bp empty", out_valid, 0);

      out_ready = 1'b0;
      push_word(32'hFFFFFFFF, 32'h200);
      for (int i = 1; i < 4; i++) push_word(32'h00100093, 32'h200 + 4 * i);
      check("flush pre ready", in_ready, 1);
      check("flush pre illegal", illegal, 1);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h2F0; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush out_valid", out_valid, 0);
      check("flush in_ready", in_ready, 1);
      check("flush cnt", illegal_cnt, 0);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush nothing emerges", seen, 0);
      expect_word(32'h00300093, 32'h300, C_ADDI);
      push_word(32'h00300093, 32'h300);
      in_valid = 1'b0;
      drain(1, "post flush", 1'b0);

      fork
         begin
            for (int i = 0; i < 5; i++) begin
               expect_word(sw_instr[9 + (i % 4)], 32'h400 + 4 * i, C_ILL);
               push_word(sw_instr[9 + (i % 4)], 32'h400 + 4 * i);
            end
            in_valid = 1'b0;
         end
         drain(5, "sat", 1'b1);
      join
      check("sat cnt", illegal_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
